// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: state encoding seen on db_estado and
// a counter-width helper.
package jogo_pkg;

  localparam int DB_W = 4;

  typedef enum logic [DB_W-1:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    MOSTRA   = 4'd2,
    APAGA    = 4'd3,
    ESPERA   = 4'd4,
    REGISTRA = 4'd5,
    COMPARA  = 4'd6,
    PROXIMA  = 4'd7,
    ACERTOU  = 4'd8,
    ERROU    = 4'd9
  } estado_t;

  // Width of a counter that runs 0..m-1; never narrower than one bit.
  function automatic int cw(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/jogo_memoria_param_contador.sv
// Modulo-MODULO up-counter: zera clears, conta advances, fim flags the last
// value, and the count wraps to zero when it advances past fim.
module contador_m
  import jogo_pkg::*;
#(
  parameter int  MODULO = 2,
  localparam int W      = cw(MODULO)
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  assign fim = (q == W'(MODULO - 1));

  always_ff @(posedge clock) begin
    if (zera)       q <= '0;
    else if (conta) q <= fim ? '0 : q + 1'b1;
  end

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory game: shows a growing sequence on the LEDs and checks the player's
// answers. Defining JOGO_MEMORIA_TIMEOUT_EN adds the between-plays timeout.
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int  NUM_BOTOES     = 4,
  parameter int  PROF           = 16,
  parameter int  TEMPO_LED      = 1000,
  parameter int  TIMEOUT_CICLOS = 5000,
  localparam int AW             = $clog2(PROF),
  localparam int DW             = $clog2(NUM_BOTOES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jogar,
  input  logic [NUM_BOTOES-1:0] botoes,
  input  logic                  seq_we,
  input  logic [AW-1:0]         seq_addr,
  input  logic [DW-1:0]         seq_dado,
  output logic [NUM_BOTOES-1:0] leds,
  output logic                  pronto,
  output logic                  ganhou,
  output logic                  perdeu,
  output logic [DB_W-1:0]       db_estado
);

  estado_t estado, prox;

  logic [DW-1:0]         mem [PROF];
  logic [AW-1:0]         addr, limite;
  logic [NUM_BOTOES-1:0] jogada, esperado;
  logic                  botoes_ant, play, ultimo, expirou;
  logic                  addr_zera, addr_conta, lim_zera, lim_conta;
  logic                  lim_fim, led_fim, addr_fim_unused;
  logic [cw(TEMPO_LED)-1:0] led_q_unused;

  always_ff @(posedge clock) begin
    if (seq_we && (estado == INICIAL || estado == ACERTOU || estado == ERROU))
      mem[seq_addr] <= seq_dado;
  end

  // A play is the rising edge of "any button"; a held button counts once.
  always_ff @(posedge clock) begin
    if (reset) botoes_ant <= 1'b0;
    else       botoes_ant <= |botoes;
  end
  assign play = (|botoes) & ~botoes_ant;

  always_ff @(posedge clock) begin
    if (reset)                  jogada <= '0;
    else if (estado == REGISTRA) jogada <= botoes;
  end

  assign esperado = NUM_BOTOES'(1) << mem[addr];
  assign ultimo   = (addr == limite);

  contador_m #(.MODULO(PROF)) u_addr (
    .clock(clock), .zera(reset || addr_zera), .conta(addr_conta),
    .q(addr), .fim(addr_fim_unused)
  );

  contador_m #(.MODULO(PROF)) u_limite (
    .clock(clock), .zera(reset || lim_zera), .conta(lim_conta),
    .q(limite), .fim(lim_fim)
  );

  // LED timer free-runs through MOSTRA/APAGA and wraps at each phase change.
  contador_m #(.MODULO(TEMPO_LED)) u_led (
    .clock(clock), .zera(reset || !(estado == MOSTRA || estado == APAGA)),
    .conta(estado == MOSTRA || estado == APAGA),
    .q(led_q_unused), .fim(led_fim)
  );

`ifdef JOGO_MEMORIA_TIMEOUT_EN
  logic [cw(TIMEOUT_CICLOS)-1:0] tmo_q_unused;

  contador_m #(.MODULO(TIMEOUT_CICLOS)) u_tmo (
    .clock(clock), .zera(reset || estado != ESPERA || play),
    .conta(estado == ESPERA), .q(tmo_q_unused), .fim(expirou)
  );
`else
  localparam int tmo_unused = TIMEOUT_CICLOS;
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox       = estado;
    addr_zera  = 1'b0;
    addr_conta = 1'b0;
    lim_zera   = 1'b0;
    lim_conta  = 1'b0;
    unique case (estado)
      INICIAL:  if (jogar) prox = PREPARA;
      PREPARA: begin
        addr_zera = 1'b1;
        lim_zera  = 1'b1;
        prox      = MOSTRA;
      end
      MOSTRA:   if (led_fim) prox = APAGA;
      APAGA:
        if (led_fim) begin
          if (ultimo) begin
            addr_zera = 1'b1;
            prox      = ESPERA;
          end else begin
            addr_conta = 1'b1;
            prox       = MOSTRA;
          end
        end
      // A play in the expiry cycle still wins.
      ESPERA:
        if (play)         prox = REGISTRA;
        else if (expirou) prox = ERROU;
      REGISTRA: prox = COMPARA;
      COMPARA:
        if (jogada != esperado) prox = ERROU;
        else if (ultimo)        prox = PROXIMA;
        else begin
          addr_conta = 1'b1;
          prox       = ESPERA;
        end
      PROXIMA:
        if (lim_fim) prox = ACERTOU;
        else begin
          lim_conta = 1'b1;
          addr_zera = 1'b1;
          prox      = MOSTRA;
        end
      ACERTOU, ERROU: if (jogar) prox = PREPARA;
      default:  prox = INICIAL;
    endcase
  end

  assign leds      = (estado == MOSTRA) ? esperado : '0;
  assign pronto    = (estado == ACERTOU) || (estado == ERROU);
  assign ganhou    = (estado == ACERTOU);
  assign perdeu    = (estado == ERROU);
  assign db_estado = estado;

endmodule
